// File: rtl/sram_access_ctrl.sv
// -----------------------------------------------------------------------------
// sram_access_ctrl
//
// Sequences every SRAM access for the SLC-3 datapath. It sits between the
// ISDU/MAR/MDR and the SRAM pins. It accepts one read or write at a time and
// drives the active-low SRAM strobes with programmable wait states. It also
// controls write-data bus turnaround, captures read data and returns a
// one-cycle ready pulse (R) to the ISDU.
//
// Optional build macro: SRAM_WRITE_VERIFY_EN
//   When defined, every write is followed by a read-back (VF_ACC) of the same
//   address. Verify_Err flags any enabled byte that did not match.
//   When undefined, Verify_Err is tied low.
//
// Parameters
//   WAIT_CYCLES : cycles OE (read) or WE (write) is held low; 0 behaves as 1
//
// Ports
//   Clk         in   system clock, rising edge
//   Reset       in   synchronous, active-high reset
//   Req_Rd      in   read request level, sampled only in IDLE
//   Req_Wr      in   write request level, sampled only in IDLE (wins over read)
//   Addr        in   [15:0] access address (MAR_out)
//   Wr_Data     in   [15:0] write data (MDR_out)
//   Byte_En     in   [1:0] [1]=upper byte, [0]=lower byte
//   Data_In     in   [15:0] data returned by the SRAM
//   Busy        out  high in every non-IDLE state
//   R           out  one-cycle completion pulse
//   LD_MDR_MEM  out  one-cycle pulse with R, reads only
//   Rd_Data     out  [15:0] registered read data (disabled bytes read as 0x00)
//   ADDR        out  [15:0] latched address to the SRAM
//   Data_Out    out  [15:0] latched write data
//   Data_OE     out  enable for the external write-data tri-buffer
//   CE,UB,LB,OE,WE out SRAM strobes, active-low
//   Verify_Err  out  write read-back mismatch, coincident with R
// -----------------------------------------------------------------------------
module sram_access_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req_Rd,
  input  logic        Req_Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] Wr_Data,
  input  logic [1:0]  Byte_En,
  input  logic [15:0] Data_In,
  output logic        Busy,
  output logic        R,
  output logic        LD_MDR_MEM,
  output logic [15:0] Rd_Data,
  output logic [15:0] ADDR,
  output logic [15:0] Data_Out,
  output logic        Data_OE,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE,
  output logic        Verify_Err
);

  localparam int W_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CNT_W = $clog2(W_EFF + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W_EFF - 1);

`ifdef SRAM_WRITE_VERIFY_EN
  typedef enum logic [2:0] {
    IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD, DONE, VF_ACC
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD, DONE
  } state_t;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_be;
  logic             r_is_rd;
  logic             w_accept;
  logic             w_timed;
  logic             w_cnt_last;

  // Zero out the bytes that were not enabled for this access.
  function automatic logic [15:0] f_mask_bytes(input logic [15:0] d,
                                               input logic [1:0]  be);
    f_mask_bytes = {(be[1] ? d[15:8] : 8'h00), (be[0] ? d[7:0] : 8'h00)};
  endfunction

  assign w_accept   = (r_state == IDLE) && (Req_Rd || Req_Wr);
  assign w_cnt_last = (r_cnt == CNT_LAST);

`ifdef SRAM_WRITE_VERIFY_EN
  assign w_timed = (r_state == RD_ACC) || (r_state == WR_PULSE) ||
                   (r_state == VF_ACC);
`else
  assign w_timed = (r_state == RD_ACC) || (r_state == WR_PULSE);
`endif

  // ---- state register ----
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (Req_Wr || Req_Rd) begin
          // A request with no bytes enabled completes without touching the SRAM.
          if (Byte_En == 2'b00) w_next = DONE;
          else if (Req_Wr)      w_next = WR_SETUP;
          else                  w_next = RD_ACC;
        end
      end
      RD_ACC:   if (w_cnt_last) w_next = DONE;
      WR_SETUP: w_next = WR_PULSE;
      WR_PULSE: if (w_cnt_last) w_next = WR_HOLD;
`ifdef SRAM_WRITE_VERIFY_EN
      WR_HOLD:  w_next = VF_ACC;
      VF_ACC:   if (w_cnt_last) w_next = DONE;
`else
      WR_HOLD:  w_next = DONE;
`endif
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // ---- wait counter: cleared on every state change, saturates at CNT_LAST ----
  always_ff @(posedge Clk) begin
    if (Reset || (w_next != r_state)) r_cnt <= '0;
    else if (w_timed && !w_cnt_last)  r_cnt <= r_cnt + 1'b1;
  end

  // ---- request latch and read capture ----
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ADDR     <= '0;
      Data_Out <= '0;
      Rd_Data  <= '0;
      r_be     <= '0;
      r_is_rd  <= 1'b0;
    end else begin
      if (w_accept) begin
        ADDR     <= Addr;
        Data_Out <= Wr_Data;
        r_be     <= Byte_En;
        r_is_rd  <= !Req_Wr;
      end
      if ((r_state == RD_ACC) && w_cnt_last)
        Rd_Data <= f_mask_bytes(Data_In, r_be);
    end
  end

`ifdef SRAM_WRITE_VERIFY_EN
  logic r_verr;

  // ---- read-back compare at the end of the verify access ----
  always_ff @(posedge Clk) begin
    if (Reset || w_accept)
      r_verr <= 1'b0;
    else if ((r_state == VF_ACC) && w_cnt_last)
      r_verr <= (f_mask_bytes(Data_In, r_be) != f_mask_bytes(Data_Out, r_be));
  end

  assign Verify_Err = (r_state == DONE) && r_verr;
`else
  assign Verify_Err = 1'b0;
`endif

  // ---- strobe decode (Moore, from registered state) ----
  always_comb begin
    CE         = 1'b1;
    OE         = 1'b1;
    WE         = 1'b1;
    UB         = 1'b1;
    LB         = 1'b1;
    Data_OE    = 1'b0;
    R          = 1'b0;
    LD_MDR_MEM = 1'b0;
    Busy       = (r_state != IDLE);
    case (r_state)
`ifdef SRAM_WRITE_VERIFY_EN
      RD_ACC, VF_ACC: begin
`else
      RD_ACC: begin
`endif
        CE = 1'b0;
        OE = 1'b0;
        UB = ~r_be[1];
        LB = ~r_be[0];
      end
      WR_SETUP, WR_HOLD: begin
        CE      = 1'b0;
        Data_OE = 1'b1;
        UB      = ~r_be[1];
        LB      = ~r_be[0];
      end
      WR_PULSE: begin
        CE      = 1'b0;
        Data_OE = 1'b1;
        WE      = 1'b0;
        UB      = ~r_be[1];
        LB      = ~r_be[0];
      end
      DONE: begin
        R          = 1'b1;
        LD_MDR_MEM = r_is_rd;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
module tb_sram_access_ctrl;

  localparam int W = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req_Rd, Req_Wr;
  logic [15:0] Addr, Wr_Data, Data_In;
  logic [1:0]  Byte_En;
  logic        Busy, R, LD_MDR_MEM, Data_OE, CE, UB, LB, OE, WE, Verify_Err;
  logic [15:0] Rd_Data, ADDR, Data_Out;

  sram_access_ctrl #(.WAIT_CYCLES(W)) dut (
    .Clk(Clk), .Reset(Reset), .Req_Rd(Req_Rd), .Req_Wr(Req_Wr),
    .Addr(Addr), .Wr_Data(Wr_Data), .Byte_En(Byte_En), .Data_In(Data_In),
    .Busy(Busy), .R(R), .LD_MDR_MEM(LD_MDR_MEM), .Rd_Data(Rd_Data),
    .ADDR(ADDR), .Data_Out(Data_Out), .Data_OE(Data_OE),
    .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .Verify_Err(Verify_Err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] rd;
    logic        ld;
    logic [15:0] addr;
    logic [15:0] dout;
    logic        verr;
    int          rcyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mask(input logic [15:0] d, input logic [1:0] be);
    mask = {(be[1] ? d[15:8] : 8'h00), (be[0] ? d[7:0] : 8'h00)};
  endfunction

  // Expected {CE,OE,WE,Data_OE,UB,LB,R,Busy} at cycle n+k of an access.
  function automatic logic [7:0] exp_strb(input bit wr, input logic [1:0] be, input int k);
    logic ce, oe, we, doe, ub, lb, r;
    ce = 1; oe = 1; we = 1; doe = 0; ub = 1; lb = 1; r = 0;
    if (be == 2'b00) begin
      if (k == 1) r = 1;
    end else if (!wr) begin
      if (k <= W) begin ce = 0; oe = 0; ub = ~be[1]; lb = ~be[0]; end
      else if (k == W + 1) r = 1;
    end else begin
      if (k == 1) begin ce = 0; doe = 1; ub = ~be[1]; lb = ~be[0]; end
      else if (k <= W + 1) begin ce = 0; doe = 1; we = 0; ub = ~be[1]; lb = ~be[0]; end
      else if (k == W + 2) begin ce = 0; doe = 1; ub = ~be[1]; lb = ~be[0]; end
`ifdef SRAM_WRITE_VERIFY_EN
      else if (k <= 2 * W + 2) begin ce = 0; oe = 0; ub = ~be[1]; lb = ~be[0]; end
      else if (k == 2 * W + 3) r = 1;
`else
      else if (k == W + 3) r = 1;
`endif
    end
    exp_strb = {ce, oe, we, doe, ub, lb, r, 1'b1};
  endfunction

  // Scoreboard consumer: every R pulse pops one expected completion.
  always @(negedge Clk) begin
    exp_t e;
    if (R) begin
      if (sb_q.size() == 0) chk("spurious_R", 32'd1, 32'd0);
      else begin
        e = sb_q.pop_front();
        chk("r_cycle", cyc, e.rcyc);
        chk("rd_data", Rd_Data, e.rd);
        chk("ld_mdr", LD_MDR_MEM, e.ld);
        chk("addr_at_R", ADDR, e.addr);
        chk("dout_at_R", Data_Out, e.dout);
        chk("verify_err", Verify_Err, e.verr);
      end
    end else begin
      chk("verr_no_R", Verify_Err, 1'b0);
    end
    chk("oe_vs_doe", (~OE) & Data_OE, 1'b0);
  end

  // Issue one access at the current negedge (cycle n), hold the request until
  // R, and check strobes every cycle. rst_at>0 asserts Reset at cycle n+rst_at.
  task automatic access(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] wd, input logic [1:0] be,
                        input logic [15:0] din, input int rst_at);
    int   t, n0, L;
    exp_t e;
    t = 0;
    while (Busy && t < 20) begin @(negedge Clk); t++; end
    chk("idle_before_req", Busy, 1'b0);
    if (be == 2'b00)  L = 1;
    else if (wr) begin
`ifdef SRAM_WRITE_VERIFY_EN
      L = 2 * W + 3;
`else
      L = W + 3;
`endif
    end else          L = W + 1;
    Req_Rd = rd; Req_Wr = wr; Addr = a; Wr_Data = wd; Byte_En = be; Data_In = din;
    n0 = cyc;
    if (rst_at == 0) begin
      if (!wr && be != 2'b00) last_rd = mask(din, be);
      e.rd   = last_rd;
      e.ld   = !wr;
      e.addr = a;
      e.dout = wd;
`ifdef SRAM_WRITE_VERIFY_EN
      e.verr = wr && (be != 2'b00) && (mask(din, be) != mask(wd, be));
`else
      e.verr = 1'b0;
`endif
      e.rcyc = n0 + L;
      sb_q.push_back(e);
    end
    for (int k = 1; k <= L; k++) begin
      @(negedge Clk);
      chk($sformatf("strb_k%0d", k), {CE, OE, WE, Data_OE, UB, LB, R, Busy},
          exp_strb(wr, be, k));
      chk($sformatf("addr_k%0d", k), ADDR, a);
      chk($sformatf("dout_k%0d", k), Data_Out, wd);
      // Change the request-side buses: the latched copies must not follow.
      Addr = ~a; Wr_Data = ~wd; Byte_En = ~be;
      if (k == rst_at) begin
        Reset = 1'b1; Req_Rd = 0; Req_Wr = 0;
        @(negedge Clk);
        chk("rst_strb", {CE, OE, WE, Data_OE, UB, LB, R, Busy}, 8'b1110_1100);
        chk("rst_addr", ADDR, 16'h0);
        chk("rst_rd", Rd_Data, 16'h0);
        last_rd = 16'h0;
        Reset = 1'b0;
        return;
      end
      if (k == L) begin Req_Rd = 0; Req_Wr = 0; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rw, rdin;
    logic [1:0]  rbe;
    bit          rwr;
    Reset = 1; Req_Rd = 0; Req_Wr = 0; Addr = 0; Wr_Data = 0; Byte_En = 0; Data_In = 0;
    last_rd = 16'h0;
    repeat (2) @(negedge Clk);
    chk("reset_strb", {CE, OE, WE, Data_OE, UB, LB, R, Busy}, 8'b1110_1100);
    chk("reset_ld_verr", {LD_MDR_MEM, Verify_Err}, 2'b00);
    chk("reset_rd", Rd_Data, 16'h0);
    chk("reset_addr", ADDR, 16'h0);
    chk("reset_dout", Data_Out, 16'h0);
    Reset = 0;
    @(negedge Clk);

    access(1, 0, 16'h0012, 16'h0000, 2'b11, 16'hBEEF, 0);   // full read
    access(0, 1, 16'h0040, 16'h1234, 2'b11, 16'h1234, 0);   // full write
    access(1, 0, 16'h0033, 16'h0000, 2'b10, 16'hABCD, 0);   // upper byte read
    access(1, 0, 16'h0034, 16'h0000, 2'b01, 16'h5A3C, 0);   // lower byte read
    access(1, 1, 16'h0041, 16'h9876, 2'b11, 16'h9876, 0);   // both requests: write wins
    access(0, 1, 16'h0042, 16'h4321, 2'b11, 16'h4321, 2);   // reset mid-write
    access(1, 0, 16'h0043, 16'h0000, 2'b11, 16'hC0DE, 0);   // read after reset
    access(1, 0, 16'h0044, 16'h0000, 2'b00, 16'hFFFF, 0);   // zero-byte read
    access(0, 1, 16'h0050, 16'h1234, 2'b11, 16'h1235, 0);   // read-back mismatch
    access(0, 1, 16'h0051, 16'hAA55, 2'b01, 16'h0055, 0);   // byte write, upper differs
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom); rw = 16'($urandom); rbe = 2'($urandom);
      rwr = 1'($urandom); rdin = (i % 2 == 0) ? rw : 16'($urandom);
      access(!rwr, rwr, ra, rw, rbe, rdin, 0);
    end
    repeat (3) @(negedge Clk);
    chk("sb_empty", sb_q.size(), 0);
    chk("final_idle", Busy, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
Sequences every SRAM access for the SLC-3 datapath.
- Sits between the ISDU/MAR/MDR and the SRAM pins.
- Accepts one read or write request at a time and drives the active-low CE/UB/LB/OE/WE strobes with programmable wait states.
- Controls write-data bus turnaround, captures read data and returns a one-cycle ready pulse (R) so the ISDU can leave its memory-wait states.

Parameters:
WAIT_CYCLES, 2, number of cycles the read strobe (OE) or write strobe (WE) is held active; a value of 0 is treated as 1.

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
Req_Rd  in  1  read request, level, sampled only in IDLE
Req_Wr  in  1  write request, level, sampled only in IDLE
Addr  in  16  access address (MAR_out)
Wr_Data  in  16  write data (MDR_out)
Byte_En  in  2  [1]=upper byte, [0]=lower byte
Data_In  in  16  data returned by the SRAM
Busy  out  1  high in every non-IDLE state
R  out  1  one-cycle completion pulse
LD_MDR_MEM  out  1  one-cycle pulse coincident with R, reads only
Rd_Data  out  16  registered read data
ADDR  out  16  latched address to the SRAM
Data_Out  out  16  latched write data
Data_OE  out  1  enable for the external write-data tri-buffer
CE, UB, LB, OE, WE  out  1 each  SRAM strobes, active-low
Verify_Err  out  1  see Optional Feature

Behaviour:
Reset (synchronous, active-high):
- State goes to IDLE.
- CE=UB=LB=OE=WE=1; Data_OE=0; Busy=R=LD_MDR_MEM=Verify_Err=0.
- Rd_Data=0, ADDR=0, Data_Out=0.
- Reset overrides any in-flight access: on the cycle after Reset is sampled, all strobes are inactive and no R is issued.

States: IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD, DONE; add VF_ACC when the optional feature is compiled in.

IDLE, request sampled in cycle n:
- Addr, Wr_Data and Byte_En are latched.
- If Req_Wr=1, go to WR_SETUP. Write wins when Req_Wr and Req_Rd are both high.
- Else if Req_Rd=1, go to RD_ACC.
- If Byte_En=00, go straight to DONE with no strobes asserted; R is high in cycle n+1.
- Requests arriving while Busy=1 are ignored, not queued. The ISDU holds the request level until it sees R.

RD_ACC, cycles n+1 .. n+W (W = WAIT_CYCLES):
- CE=0, OE=0, WE=1.
- UB = ~Byte_En[1]; LB = ~Byte_En[0].
- At the end of the last RD_ACC cycle, Rd_Data <= Data_In; bytes not enabled are written as 0x00.
- Then go to DONE.

WR_SETUP, cycle n+1:
- CE=0, Data_OE=1, WE=1, OE=1, UB/LB per Byte_En.

WR_PULSE, cycles n+2 .. n+W+1:
- As WR_SETUP, but WE=0.

WR_HOLD, cycle n+W+2:
- WE=1; CE and Data_OE stay asserted.

DONE:
- R=1 for one cycle.
- LD_MDR_MEM=1 if the access was a read.
- All strobes inactive; Data_OE=0.
- Next state is IDLE.

Latency:
- Read: R at cycle n+W+1.
- Write: R at cycle n+W+3.
- A new request is accepted no earlier than the cycle after DONE.

Invariants:
- OE=0 and Data_OE=1 never occur in the same cycle.
- ADDR and Data_Out are stable from the cycle after acceptance through DONE.
- The wait counter is $clog2(W+1) bits wide, clears on every state entry, and never wraps.

Optional Feature:
Macro: SRAM_WRITE_VERIFY_EN

Defined:
- After WR_HOLD the block enters VF_ACC for W cycles, performing a read access (strobes as in RD_ACC) at the same address.
- Enabled bytes of Data_In are compared against Data_Out.
- Verify_Err=1 coincident with R on a mismatch. Rd_Data is not updated.
- Write latency becomes n+2W+3.

Undefined:
- No VF_ACC state; Verify_Err is tied to 0.

Test Plan (WAIT_CYCLES=2):
1. Read, Addr=0x0012, Byte_En=11, Data_In=0xBEEF -> CE/OE low in cycles n+1..n+2; R and LD_MDR_MEM high at n+3; Rd_Data=0xBEEF; WE and Data_OE stay inactive throughout.
2. Write, Addr=0x0040, Wr_Data=0x1234, Byte_En=11 -> Data_OE high n+1..n+4; WE low n+2..n+3; R at n+5; ADDR=0x0040 and Data_Out=0x1234 stable through n+5.
3. Byte read, Byte_En=10, Data_In=0xABCD -> UB=0, LB=1 during access; Rd_Data=0xAB00.
4. Req_Rd=Req_Wr=1 in IDLE -> write sequence as in scenario 2; OE never low; LD_MDR_MEM never pulses.
5. Reset sampled at cycle n+2 of a write -> at n+3 all strobes=1, Data_OE=0, Busy=0, no R; a read issued afterwards completes normally.
6. Byte_En=00 read -> R at n+1, no strobe activity. With SRAM_WRITE_VERIFY_EN: write 0x1234 while Data_In returns 0x1235 -> Verify_Err=1 together with R at n+7.
